// File: rtl/dm_pkg.sv
// Debug-module DMI types, response codes, register addresses and register layouts.
// Shared by the DMI responder and anything else talking dm::dmi_req_t / dmi_resp_t.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  localparam logic [6:0] Data0     = 7'h04;
  localparam logic [6:0] DMControl = 7'h10;
  localparam logic [6:0] DMStatus  = 7'h11;
  localparam logic [6:0] HartInfo  = 7'h12;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef struct packed {
    logic        haltreq;
    logic        resumereq;
    logic [29:2] zero0;
    logic        ndmreset;
    logic        dmactive;
  } dmcontrol_t;

  typedef struct packed {
    logic [31:18] zero2;
    logic         allresumeack;
    logic         anyresumeack;
    logic [15:12] zero1;
    logic         allrunning;
    logic         anyrunning;
    logic         allhalted;
    logic         anyhalted;
    logic         authenticated;
    logic [6:4]   zero0;
    logic [3:0]   version;
  } dmstatus_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } dmi_state_e;

endpackage

// File: rtl/dm_dmi_responder.sv
// DMI target for a single-hart debug module: handshake FSM plus DM register set.
// Define DM_DMI_ADDR_ERR_EN to answer unmapped addresses with DTM_ERR.
module dm_dmi_responder
  import dm::*;
#(
  parameter int unsigned DataCount = 2
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            dmi_clear_i,
  input  dmi_req_t        dmi_req_i,
  input  logic            dmi_req_valid_i,
  output logic            dmi_req_ready_o,
  output dmi_resp_t       dmi_resp_o,
  output logic            dmi_resp_valid_o,
  input  logic            dmi_resp_ready_i,
  input  logic            halted_i,
  input  logic            resumeack_i,
  output logic            dmactive_o,
  output logic            ndmreset_o,
  output logic            haltreq_o,
  output logic            resumereq_o
);

`ifdef DM_DMI_ADDR_ERR_EN
  localparam bit AddrErr = 1'b1;
`else
  localparam bit AddrErr = 1'b0;
`endif

  dmi_state_e state_q, state_d;
  dmi_resp_t  resp_q, resp_d;

  logic        dmactive_q, dmactive_d;
  logic        ndmreset_q, ndmreset_d;
  logic        haltreq_q, haltreq_d;
  logic        resumereq_q;
  logic        ack_q, ack_d;
  logic [31:0] data_q [DataCount];

  logic                 accept;
  logic [DataCount-1:0] hit_data;
  logic                 is_ctl, is_stat, is_info;
  logic                 mapped;
  logic [31:0]          rdata;
  logic                 wr;
  logic                 we_ctl;
  logic                 keep;
  logic                 resume_set;
  dmcontrol_t           ctl_r, ctl_w;
  dmstatus_t            stat_r;

  assign accept = dmi_req_valid_i && dmi_req_ready_o;
  assign ctl_w  = dmcontrol_t'(dmi_req_i.data);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: if (dmi_resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dmi_clear_i) state_d = IDLE;
  end

  // Gating with clear keeps a same-cycle request from handshaking.
  always_comb begin
    dmi_req_ready_o  = (state_q == IDLE) && !dmi_clear_i;
    dmi_resp_valid_o = (state_q == RESP);
  end

  always_comb begin
    ctl_r           = '0;
    ctl_r.haltreq   = haltreq_q;
    ctl_r.ndmreset  = ndmreset_q;
    ctl_r.dmactive  = dmactive_q;
    stat_r               = '0;
    stat_r.allresumeack  = ack_q;
    stat_r.anyresumeack  = ack_q;
    stat_r.allrunning    = ~halted_i;
    stat_r.anyrunning    = ~halted_i;
    stat_r.allhalted     = halted_i;
    stat_r.anyhalted     = halted_i;
    stat_r.authenticated = 1'b1;
    stat_r.version       = 4'd2;
  end

  always_comb begin
    hit_data = '0;
    rdata    = '0;
    is_ctl   = (dmi_req_i.addr == DMControl);
    is_stat  = (dmi_req_i.addr == DMStatus);
    is_info  = (dmi_req_i.addr == HartInfo);
    for (int i = 0; i < DataCount; i++) begin
      if (dmi_req_i.addr == Data0 + 7'(i)) begin
        hit_data[i] = 1'b1;
        rdata       = data_q[i];
      end
    end
    unique case (1'b1)
      is_ctl:  rdata = ctl_r;
      is_stat: rdata = stat_r;
      is_info: rdata = 32'(DataCount) << 12;
      default: ;
    endcase
    mapped = (|hit_data) || is_ctl || is_stat || is_info;
  end

  always_comb begin
    resp_d = '{data: 32'h0, resp: DTM_SUCCESS};
    wr     = 1'b0;
    unique case (dmi_req_i.op)
      DTM_NOP: ;
      DTM_READ: begin
        if (!mapped && AddrErr) resp_d.resp = DTM_ERR;
        else                    resp_d.data = rdata;
      end
      DTM_WRITE: begin
        if (!mapped && AddrErr) begin
          resp_d.resp = DTM_ERR;
        end else begin
          resp_d.data = dmi_req_i.data;
          wr          = mapped;
        end
      end
      default: resp_d.resp = DTM_ERR;
    endcase
  end

  // keep: the DM is active now and stays active; otherwise state collapses to 0.
  always_comb begin
    we_ctl     = accept && wr && is_ctl;
    dmactive_d = we_ctl ? ctl_w.dmactive : dmactive_q;
    keep       = dmactive_q && dmactive_d;
    haltreq_d  = 1'b0;
    ndmreset_d = 1'b0;
    if (keep) begin
      haltreq_d  = we_ctl ? ctl_w.haltreq : haltreq_q;
      ndmreset_d = we_ctl ? ctl_w.ndmreset : ndmreset_q;
    end
    resume_set = we_ctl && keep && ctl_w.resumereq && !ctl_w.haltreq;
    if (resume_set || (dmactive_q && !dmactive_d)) ack_d = 1'b0;
    else if (resumeack_i)                          ack_d = 1'b1;
    else                                           ack_d = ack_q;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      dmactive_q  <= 1'b0;
      ndmreset_q  <= 1'b0;
      haltreq_q   <= 1'b0;
      resumereq_q <= 1'b0;
      ack_q       <= 1'b0;
      for (int i = 0; i < DataCount; i++) data_q[i] <= '0;
    end else begin
      dmactive_q  <= dmactive_d;
      ndmreset_q  <= ndmreset_d;
      haltreq_q   <= haltreq_d;
      resumereq_q <= resume_set;
      ack_q       <= ack_d;
      for (int i = 0; i < DataCount; i++) begin
        if (!keep)
          data_q[i] <= '0;
        else if (accept && wr && hit_data[i])
          data_q[i] <= dmi_req_i.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)          resp_q <= '0;
    else if (dmi_clear_i) resp_q <= '0;
    else if (accept)      resp_q <= resp_d;
  end

  assign dmi_resp_o  = resp_q;
  assign dmactive_o  = dmactive_q;
  assign ndmreset_o  = ndmreset_q;
  assign haltreq_o   = haltreq_q;
  assign resumereq_o = resumereq_q;

endmodule

// File: tb/tb_dm_dmi_responder.sv
// Directed bench for dm_dmi_responder (DataCount=2).
// Expected values are hand-derived from the DM register map.
module tb_dm_dmi_responder;
  import dm::*;

  logic      clk = 1'b0;
  logic      rst_ni = 1'b0;
  logic      dmi_clear = 1'b0;
  dmi_req_t  req = '0;
  logic      req_valid = 1'b0;
  logic      req_ready;
  dmi_resp_t resp;
  logic      resp_valid;
  logic      resp_ready = 1'b0;
  logic      halted = 1'b0;
  logic      resumeack = 1'b0;
  logic      dmactive, ndmreset, haltreq, resumereq;

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;
  logic ready_in_resp;

  always #5 clk = ~clk;

  always @(posedge clk) if (resumereq) pulse_cnt++;

  dm_dmi_responder #(.DataCount(2)) dut (
    .clk              (clk),
    .rst_ni           (rst_ni),
    .dmi_clear_i      (dmi_clear),
    .dmi_req_i        (req),
    .dmi_req_valid_i  (req_valid),
    .dmi_req_ready_o  (req_ready),
    .dmi_resp_o       (resp),
    .dmi_resp_valid_o (resp_valid),
    .dmi_resp_ready_i (resp_ready),
    .halted_i         (halted),
    .resumeack_i      (resumeack),
    .dmactive_o       (dmactive),
    .ndmreset_o       (ndmreset),
    .haltreq_o        (haltreq),
    .resumereq_o      (resumereq)
  );

  task automatic dmi_txn(input logic [6:0] a, input logic [1:0] op,
                         input logic [31:0] d,
                         output logic [31:0] rd, output logic [1:0] rs);
    int n;
    @(negedge clk);
    req.addr = a;
    req.op = dtm_op_e'(op);
    req.data = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    ready_in_resp = req_ready;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      total++;
      bad++;
      $display("FAIL txn_timeout addr=%h got valid=0 want 1", a);
    end
    rd = resp.data;
    rs = resp.resp;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    resumeack = 1'b1;
    @(negedge clk);
    resumeack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [1:0] rs;
    @(negedge clk);
    total++;
    if ({dmactive, ndmreset, haltreq, resumereq, resp_valid} !== 5'b0
        || resp !== '0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outs got %b%b%b%b%b resp=%h rdy=%b want 0 0 1",
               dmactive, ndmreset, haltreq, resumereq, resp_valid,
               resp, req_ready);
    end
    dmi_txn(7'h11, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h0000_0C82 || rs !== DTM_SUCCESS) begin
      bad++;
      $display("FAIL status_read got %h/%0d want 00000c82/0", rd, rs);
    end
    total++;
    if (ready_in_resp !== 1'b0) begin
      bad++;
      $display("FAIL ready_in_resp got %b want 0", ready_in_resp);
    end
  endtask

  task automatic test_data_regs();
    logic [31:0] rd;
    logic [1:0] rs;
    dmi_txn(7'h10, 2'd2, 32'h1, rd, rs);
    total++;
    if (rd !== 32'h1 || rs !== DTM_SUCCESS || dmactive !== 1'b1) begin
      bad++;
      $display("FAIL activate got %h/%0d act=%b want 1/0 1", rd, rs, dmactive);
    end
    dmi_txn(7'h04, 2'd2, 32'hDEAD_BEEF, rd, rs);
    dmi_txn(7'h05, 2'd2, 32'h1234_5678, rd, rs);
    dmi_txn(7'h04, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'hDEAD_BEEF || rs !== DTM_SUCCESS) begin
      bad++;
      $display("FAIL data0_read got %h/%0d want deadbeef/0", rd, rs);
    end
    dmi_txn(7'h05, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h1234_5678) begin
      bad++;
      $display("FAIL data1_read got %h want 12345678", rd);
    end
    dmi_txn(7'h12, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h0000_2000 || rs !== DTM_SUCCESS) begin
      bad++;
      $display("FAIL hartinfo got %h/%0d want 00002000/0", rd, rs);
    end
    dmi_txn(7'h10, 2'd2, 32'h0, rd, rs);
    dmi_txn(7'h04, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h0 || dmactive !== 1'b0) begin
      bad++;
      $display("FAIL deactivate_clear got %h act=%b want 0 0", rd, dmactive);
    end
  endtask

  task automatic test_resume();
    logic [31:0] rd;
    logic [1:0] rs;
    int p0;
    dmi_txn(7'h10, 2'd2, 32'h1, rd, rs);
    pulse_ack();
    dmi_txn(7'h11, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h0003_0C82) begin
      bad++;
      $display("FAIL ack_sticky got %h want 00030c82", rd);
    end
    p0 = pulse_cnt;
    dmi_txn(7'h10, 2'd2, 32'h4000_0001, rd, rs);
    total++;
    if (pulse_cnt - p0 !== 1) begin
      bad++;
      $display("FAIL resume_pulse got %0d cycles want 1", pulse_cnt - p0);
    end
    dmi_txn(7'h11, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h0000_0C82) begin
      bad++;
      $display("FAIL ack_cleared got %h want 00000c82", rd);
    end
    pulse_ack();
    dmi_txn(7'h11, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h0003_0C82) begin
      bad++;
      $display("FAIL ack_set got %h want 00030c82", rd);
    end
    dmi_txn(7'h10, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h1) begin
      bad++;
      $display("FAIL resumereq_reads0 got %h want 00000001", rd);
    end
  endtask

  task automatic test_stall_clear();
    logic [31:0] rd;
    logic [1:0] rs;
    int n;
    int unstable;
    dmi_txn(7'h04, 2'd2, 32'hA5A5_0001, rd, rs);
    @(negedge clk);
    req.addr = 7'h04;
    req.op = DTM_READ;
    req.data = '0;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp.data !== 32'hA5A5_0001) unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL stall_stable got %0d bad cycles want 0", unstable);
    end
    req.addr = 7'h05;
    req_valid = 1'b1;
    dmi_clear = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_ready got %b want 0", req_ready);
    end
    @(posedge clk);
    #1 dmi_clear = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL clear_idle got v=%b r=%b want 0 1", resp_valid, req_ready);
    end
    dmi_txn(7'h04, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'hA5A5_0001 || rs !== DTM_SUCCESS) begin
      bad++;
      $display("FAIL after_clear got %h/%0d want a5a50001/0", rd, rs);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic [1:0] rs;
    logic [1:0] exp_rs;
`ifdef DM_DMI_ADDR_ERR_EN
    exp_rs = DTM_ERR;
`else
    exp_rs = DTM_SUCCESS;
`endif
    dmi_txn(7'h3F, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h0 || rs !== exp_rs) begin
      bad++;
      $display("FAIL unmapped_read got %h/%0d want 0/%0d", rd, rs, exp_rs);
    end
    dmi_txn(7'h06, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h0 || rs !== exp_rs) begin
      bad++;
      $display("FAIL data2_read got %h/%0d want 0/%0d", rd, rs, exp_rs);
    end
    dmi_txn(7'h04, 2'd3, 32'h5555_5555, rd, rs);
    total++;
    if (rd !== 32'h0 || rs !== DTM_ERR) begin
      bad++;
      $display("FAIL op3 got %h/%0d want 0/2", rd, rs);
    end
    dmi_txn(7'h04, 2'd0, 32'h7777_7777, rd, rs);
    total++;
    if (rd !== 32'h0 || rs !== DTM_SUCCESS) begin
      bad++;
      $display("FAIL nop got %h/%0d want 0/0", rd, rs);
    end
    dmi_txn(7'h04, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'hA5A5_0001) begin
      bad++;
      $display("FAIL no_side_effect got %h want a5a50001", rd);
    end
  endtask

  task automatic test_inactive();
    logic [31:0] rd;
    logic [1:0] rs;
    int p0;
    dmi_txn(7'h10, 2'd2, 32'h0, rd, rs);
    dmi_txn(7'h10, 2'd2, 32'h8000_0002, rd, rs);
    total++;
    if (haltreq !== 1'b0 || ndmreset !== 1'b0) begin
      bad++;
      $display("FAIL inactive_hold got h=%b n=%b want 0 0", haltreq, ndmreset);
    end
    dmi_txn(7'h10, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL inactive_read got %h want 0", rd);
    end
    dmi_txn(7'h10, 2'd2, 32'h1, rd, rs);
    dmi_txn(7'h10, 2'd2, 32'h8000_0003, rd, rs);
    total++;
    if (haltreq !== 1'b1 || ndmreset !== 1'b1) begin
      bad++;
      $display("FAIL active_ctl got h=%b n=%b want 1 1", haltreq, ndmreset);
    end
    p0 = pulse_cnt;
    dmi_txn(7'h10, 2'd2, 32'hC000_0001, rd, rs);
    total++;
    if (pulse_cnt != p0 || haltreq !== 1'b1 || ndmreset !== 1'b0) begin
      bad++;
      $display("FAIL halt_wins got p=%0d h=%b n=%b want 0 1 0",
               pulse_cnt - p0, haltreq, ndmreset);
    end
    dmi_txn(7'h10, 2'd1, 32'h0, rd, rs);
    total++;
    if (rd !== 32'h8000_0001) begin
      bad++;
      $display("FAIL ctl_read got %h want 80000001", rd);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    test_reset();
    test_data_regs();
    test_resume();
    test_stall_clear();
    test_errors();
    test_inactive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
